// File: rtl/oisc_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : oisc_mem_arbiter_pkg
// Purpose  : Shared types and constants for the OISC SDRAM port arbiter:
//            arbiter FSM state encoding and requester (owner) ids.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package oisc_mem_arbiter_pkg;

    // Arbiter FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        ArbIdle    = 2'd0,
        ArbCmd     = 2'd1,
        ArbWaitRsp = 2'd2
    } arbState_t;

    // Requester ids. They double as bit positions in the request/grant vectors.
    localparam logic OwnerIF = 1'b0;
    localparam logic OwnerDA = 1'b1;

    // Requester that gets priority on the tie after `winner` was granted.
    function automatic logic otherOwner(input logic winner);
        return (winner == OwnerIF) ? OwnerDA : OwnerIF;
    endfunction

endpackage : oisc_mem_arbiter_pkg
`default_nettype wire

// File: rtl/oisc_rr_grant2.sv
`default_nettype none
// ============================================================================
// Module   : oisc_rr_grant2
// Purpose  : Two-requester round-robin grant. The grant is combinational and
//            one-hot; the priority pointer moves to the other requester after
//            every grant (whenever en is high and at least one request is up).
// Ports    : CLK      in   clock
//            RST_N    in   asynchronous active-low reset (pointer -> IF)
//            en       in   grant is being consumed this cycle
//            req[1:0] in   requests, bit 0 = IF, bit 1 = DA
//            gnt[1:0] out  one-hot grant (all zero when no request)
// Revision : 1.0  initial release
// ============================================================================
module oisc_rr_grant2
    import oisc_mem_arbiter_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Requester that wins the next tie.
    logic rPtr;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (rPtr == OwnerDA) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rPtr <= OwnerIF;
        end else if (en && (|req)) begin
            rPtr <= otherOwner(gnt[OwnerDA]);
        end
    end

endmodule : oisc_rr_grant2
`default_nettype wire

// File: rtl/oisc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : oisc_mem_arbiter
// Purpose  : Shares one SDRAM command/response port between the OISC
//            instruction-fetch (IF, read-only) and data (DA, read/write)
//            requesters. One transaction in flight at a time, round-robin
//            arbitration, read responses routed back to the owner, and every
//            read bounded by a timeout that returns an error response.
// Ports    : CLK, RST_N                clock, async active-low reset
//            IfReq{Valid,Ready,Addr}   IF read request
//            IfRsp{Valid,Data,Err}     IF read response (1-cycle pulse)
//            DaReq{Valid,Ready,Write,Addr,WData}  DA request
//            DaRsp{Valid,Data,Err}     DA read response (1-cycle pulse)
//            MemCmd{Valid,Ready,Write,Addr,WData} SDRAM command
//            MemRsp{Valid,Data}        SDRAM read data
// Revision : 1.0  initial release
// ============================================================================
module oisc_mem_arbiter
    import oisc_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int RSP_TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST_N,

    input  logic              IfReqValid,
    output logic              IfReqReady,
    input  logic [ADDR_W-1:0] IfReqAddr,
    output logic              IfRspValid,
    output logic [DATA_W-1:0] IfRspData,
    output logic              IfRspErr,

    input  logic              DaReqValid,
    output logic              DaReqReady,
    input  logic              DaReqWrite,
    input  logic [ADDR_W-1:0] DaReqAddr,
    input  logic [DATA_W-1:0] DaReqWData,
    output logic              DaRspValid,
    output logic [DATA_W-1:0] DaRspData,
    output logic              DaRspErr,

    output logic              MemCmdValid,
    input  logic              MemCmdReady,
    output logic              MemCmdWrite,
    output logic [ADDR_W-1:0] MemCmdAddr,
    output logic [DATA_W-1:0] MemCmdWData,
    input  logic              MemRspValid,
    input  logic [DATA_W-1:0] MemRspData
);

    localparam int CNT_W = $clog2(RSP_TIMEOUT + 1);
    // Counter value in the last WAIT_RSP cycle before the timeout response.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(RSP_TIMEOUT - 1);

    arbState_t          rState;
    arbState_t          wStateNext;

    logic [1:0]         wReq;
    logic [1:0]         wGnt;
    logic               wIdle;
    logic               wAccept;
    logic               wCmdDone;
    logic               wTimeout;

    logic               rOwner;
    logic               rWrite;
    logic [ADDR_W-1:0]  rAddr;
    logic [DATA_W-1:0]  rWData;
    logic [CNT_W-1:0]   rCnt;

    logic               rIfRspValid;
    logic               rIfRspErr;
    logic [DATA_W-1:0]  rIfRspData;
    logic               rDaRspValid;
    logic               rDaRspErr;
    logic [DATA_W-1:0]  rDaRspData;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign wReq  = {DaReqValid, IfReqValid};
    assign wIdle = (rState == ArbIdle);

    oisc_rr_grant2 u_rrGrant (
        .CLK   (CLK),
        .RST_N (RST_N),
        .en    (wIdle),
        .req   (wReq),
        .gnt   (wGnt)
    );

    // Ready is combinational so a request is accepted in the cycle it is
    // first seen while idle; the one-hot grant keeps the two exclusive.
    assign IfReqReady = wIdle & wGnt[OwnerIF];
    assign DaReqReady = wIdle & wGnt[OwnerDA];
    assign wAccept    = wIdle & (|wReq);

    assign wCmdDone   = (rState == ArbCmd) & MemCmdReady;
    assign wTimeout   = (rCnt == TIMEOUT_LAST);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rState <= ArbIdle;
        end else begin
            rState <= wStateNext;
        end
    end

    always_comb begin
        wStateNext = rState;
        case (rState)
            ArbIdle: begin
                if (wAccept) begin
                    wStateNext = ArbCmd;
                end
            end
            ArbCmd: begin
                if (MemCmdReady) begin
                    wStateNext = rWrite ? ArbIdle : ArbWaitRsp;
                end
            end
            ArbWaitRsp: begin
                if (MemRspValid || wTimeout) begin
                    wStateNext = ArbIdle;
                end
            end
            default: wStateNext = ArbIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Command / owner registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rOwner <= OwnerIF;
            rWrite <= 1'b0;
            rAddr  <= '0;
            rWData <= '0;
        end else if (wAccept) begin
            rOwner <= wGnt[OwnerDA];
            rWrite <= wGnt[OwnerDA] & DaReqWrite;
            rAddr  <= wGnt[OwnerDA] ? DaReqAddr : IfReqAddr;
            rWData <= wGnt[OwnerDA] ? DaReqWData : '0;
        end
    end

    // Cycles spent in WAIT_RSP; cleared on the read command handshake.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rCnt <= '0;
        end else if (wCmdDone) begin
            rCnt <= '0;
        end else if (rState == ArbWaitRsp) begin
            rCnt <= rCnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Response routing. A response in the timeout cycle wins over the
    // error; responses outside WAIT_RSP are stray and ignored.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rIfRspValid <= 1'b0;
            rIfRspErr   <= 1'b0;
            rIfRspData  <= '0;
            rDaRspValid <= 1'b0;
            rDaRspErr   <= 1'b0;
            rDaRspData  <= '0;
        end else begin
            rIfRspValid <= 1'b0;
            rIfRspErr   <= 1'b0;
            rDaRspValid <= 1'b0;
            rDaRspErr   <= 1'b0;
            if (rState == ArbWaitRsp && (MemRspValid || wTimeout)) begin
                if (rOwner == OwnerDA) begin
                    rDaRspValid <= 1'b1;
                    rDaRspErr   <= ~MemRspValid;
                    rDaRspData  <= MemRspValid ? MemRspData : '0;
                end else begin
                    rIfRspValid <= 1'b1;
                    rIfRspErr   <= ~MemRspValid;
                    rIfRspData  <= MemRspValid ? MemRspData : '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. MemCmdValid decodes the state register directly so it
    // drops the moment reset is applied.
    // ------------------------------------------------------------------
    assign MemCmdValid = (rState == ArbCmd);
    assign MemCmdWrite = rWrite;
    assign MemCmdAddr  = rAddr;
    assign MemCmdWData = rWData;

    assign IfRspValid  = rIfRspValid;
    assign IfRspErr    = rIfRspErr;
    assign IfRspData   = rIfRspData;
    assign DaRspValid  = rDaRspValid;
    assign DaRspErr    = rDaRspErr;
    assign DaRspData   = rDaRspData;

endmodule : oisc_mem_arbiter
`default_nettype wire

// File: tb/tb_oisc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_oisc_mem_arbiter
// Purpose  : Self-checking bench for oisc_mem_arbiter. Requester and SDRAM
//            models drive random and scripted traffic; a transaction-level
//            reference (busy flag, round-robin pointer, word memory) predicts
//            grants, commands and responses into queues that a negedge
//            monitor pops and compares.
// Revision : 1.0  initial release
// ============================================================================
module tb_oisc_mem_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic          CLK;
    logic          RST_N;
    logic          IfReqValid, IfReqReady;
    logic [AW-1:0] IfReqAddr;
    logic          IfRspValid, IfRspErr;
    logic [DW-1:0] IfRspData;
    logic          DaReqValid, DaReqReady, DaReqWrite;
    logic [AW-1:0] DaReqAddr;
    logic [DW-1:0] DaReqWData;
    logic          DaRspValid, DaRspErr;
    logic [DW-1:0] DaRspData;
    logic          MemCmdValid, MemCmdReady, MemCmdWrite;
    logic [AW-1:0] MemCmdAddr;
    logic [DW-1:0] MemCmdWData;
    logic          MemRspValid;
    logic [DW-1:0] MemRspData;

    oisc_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RSP_TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IfReqValid(IfReqValid), .IfReqReady(IfReqReady), .IfReqAddr(IfReqAddr),
        .IfRspValid(IfRspValid), .IfRspData(IfRspData), .IfRspErr(IfRspErr),
        .DaReqValid(DaReqValid), .DaReqReady(DaReqReady), .DaReqWrite(DaReqWrite),
        .DaReqAddr(DaReqAddr), .DaReqWData(DaReqWData),
        .DaRspValid(DaRspValid), .DaRspData(DaRspData), .DaRspErr(DaRspErr),
        .MemCmdValid(MemCmdValid), .MemCmdReady(MemCmdReady), .MemCmdWrite(MemCmdWrite),
        .MemCmdAddr(MemCmdAddr), .MemCmdWData(MemCmdWData),
        .MemRspValid(MemRspValid), .MemRspData(MemRspData)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct { bit owner; bit wr; logic [AW-1:0] addr; logic [DW-1:0] wd; } req_t;
    typedef struct { bit owner; logic [DW-1:0] data; bit err; int due; } rsp_t;
    typedef struct { bit wr; logic [AW-1:0] addr; logic [DW-1:0] wd; } daReq_t;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference state.
    bit [DW-1:0]   mem [int];
    req_t          accQ[$];
    rsp_t          expQ[$];
    bit            busy = 0;
    bit            ptr  = 0;
    int            rdDue = -1;
    int            cmdFrom = 0;
    logic [DW-1:0] lastIf = '0, lastDa = '0;

    // Monitor -> SDRAM model hand-off for the read in flight.
    bit            rdOutstanding = 0;
    int            rspAt = -1, waitEnd = 0;
    logic [AW-1:0] rdAddr = '0;
    int            rdLat = 1;

    // Scripts and traffic knobs.
    logic [AW-1:0] ifQ[$];
    daReq_t        daQ[$];
    int            latQ[$];
    int            stallQ[$];
    bit            randEn = 0;
    bit            strayEn = 1;
    int            ifRate = 0, daRate = 0, daWrPct = 0;

    function automatic logic [DW-1:0] memRead(input int a);
        return mem.exists(a) ? mem[a] : (32'hA500_0000 ^ 32'(a));
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
        end
    endtask

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // IF requester: holds each request until it sees Ready.
    initial begin : p_if
        bit acc;
        IfReqValid = 0; IfReqAddr = '0;
        forever begin
            @(negedge CLK);
            acc = IfReqReady;
            @(posedge CLK); #1;
            if (acc) IfReqValid = 0;
            if (!IfReqValid) begin
                if (ifQ.size() > 0) begin
                    IfReqValid = 1; IfReqAddr = ifQ.pop_front();
                end else if (randEn && $urandom_range(99, 0) < 32'(ifRate)) begin
                    IfReqValid = 1; IfReqAddr = AW'($urandom_range(63, 0));
                end
            end
        end
    end

    // DA requester.
    initial begin : p_da
        bit acc;
        daReq_t d;
        DaReqValid = 0; DaReqWrite = 0; DaReqAddr = '0; DaReqWData = '0;
        forever begin
            @(negedge CLK);
            acc = DaReqReady;
            @(posedge CLK); #1;
            if (acc) DaReqValid = 0;
            if (!DaReqValid) begin
                if (daQ.size() > 0) begin
                    d = daQ.pop_front();
                    DaReqValid = 1; DaReqWrite = d.wr; DaReqAddr = d.addr; DaReqWData = d.wd;
                end else if (randEn && $urandom_range(99, 0) < 32'(daRate)) begin
                    DaReqValid = 1;
                    DaReqWrite = ($urandom_range(99, 0) < 32'(daWrPct));
                    DaReqAddr  = AW'($urandom_range(63, 0));
                    DaReqWData = $urandom;
                end
            end
        end
    end

    // SDRAM controller model. rdLat: 0 = never responds, otherwise cycles
    // from command handshake to MemRspValid.
    initial begin : p_mem
        bit prevCmd;
        int stallCnt;
        int r;
        MemCmdReady = 0; MemRspValid = 0; MemRspData = '0;
        prevCmd = 0; stallCnt = 0;
        forever begin
            @(posedge CLK); #1;
            if (!RST_N) begin
                MemCmdReady = 0; MemRspValid = 0; prevCmd = 0;
            end else begin
                if (MemCmdValid && !prevCmd) begin
                    stallCnt = (stallQ.size() > 0) ? stallQ.pop_front() : int'($urandom_range(2, 0));
                    if (latQ.size() > 0) begin
                        rdLat = latQ.pop_front();
                    end else begin
                        r = int'($urandom_range(9, 0));
                        rdLat = (r == 0) ? 0 : (r == 1) ? TMO : (r == 2) ? TMO + 1
                              : int'($urandom_range(TMO, 1));
                    end
                end
                prevCmd = MemCmdValid;
                if (MemCmdValid) begin
                    if (stallCnt > 0) begin
                        MemCmdReady = 0; stallCnt--;
                    end else begin
                        MemCmdReady = 1;
                    end
                end else begin
                    MemCmdReady = $urandom_range(1, 0) == 1;
                end
                MemRspValid = 0;
                MemRspData  = $urandom;
                if (rdOutstanding) begin
                    if (cyc == rspAt) begin
                        MemRspValid = 1; MemRspData = memRead(int'(rdAddr));
                    end
                    if (cyc >= waitEnd) rdOutstanding = 0;
                end else if (strayEn && $urandom_range(7, 0) == 0) begin
                    MemRspValid = 1;
                end
            end
        end
    end

    // Monitor / scoreboard.
    initial begin : p_mon
        bit eIf, eDa, eRI, eRD, eCmd;
        req_t r;
        rsp_t e;
        int L;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                accQ.delete(); expQ.delete();
                busy = 0; ptr = 0; rdDue = -1; cmdFrom = 0;
                lastIf = '0; lastDa = '0; rdOutstanding = 0;
            end else begin
                if (busy && rdDue == cyc) busy = 0;
                eIf = 0; eDa = 0;
                if (!busy) begin
                    if (IfReqValid && DaReqValid) begin
                        eIf = !ptr; eDa = ptr;
                    end else begin
                        eIf = IfReqValid; eDa = DaReqValid;
                    end
                end
                chk("req_ready", {126'd0, IfReqReady, DaReqReady}, {126'd0, eIf, eDa});
                if (eIf || eDa) begin
                    r.owner = eDa;
                    r.wr    = eDa && DaReqWrite;
                    r.addr  = eDa ? DaReqAddr : IfReqAddr;
                    r.wd    = eDa ? DaReqWData : '0;
                    accQ.push_back(r);
                    ptr = !eDa;
                    busy = 1;
                    cmdFrom = cyc + 1;
                end

                eRI = 0; eRD = 0;
                if (expQ.size() > 0 && expQ[0].due == cyc) begin
                    e = expQ.pop_front();
                    if (e.owner) begin
                        eRD = 1; lastDa = e.data;
                        chk("da_rsp_err", {127'd0, DaRspErr}, {127'd0, e.err});
                    end else begin
                        eRI = 1; lastIf = e.data;
                        chk("if_rsp_err", {127'd0, IfRspErr}, {127'd0, e.err});
                    end
                end
                chk("rsp_valid", {126'd0, IfRspValid, DaRspValid}, {126'd0, eRI, eRD});
                chk("if_rsp_data", {96'd0, IfRspData}, {96'd0, lastIf});
                chk("da_rsp_data", {96'd0, DaRspData}, {96'd0, lastDa});

                eCmd = (accQ.size() > 0) && (cyc >= cmdFrom);
                chk("cmd_valid", {127'd0, MemCmdValid}, {127'd0, eCmd});
                if (eCmd && MemCmdValid) begin
                    r = accQ[0];
                    chk("cmd_write_addr", {111'd0, MemCmdWrite, MemCmdAddr}, {111'd0, r.wr, r.addr});
                    if (r.wr) chk("cmd_wdata", {96'd0, MemCmdWData}, {96'd0, r.wd});
                    if (MemCmdReady) begin
                        void'(accQ.pop_front());
                        if (r.wr) begin
                            mem[int'(r.addr)] = r.wd;
                            busy = 0;
                        end else begin
                            L = rdLat;
                            e.owner = r.owner;
                            if (L > 0 && L <= TMO) begin
                                e.data = memRead(int'(r.addr)); e.err = 0; e.due = cyc + L + 1;
                            end else begin
                                e.data = '0; e.err = 1; e.due = cyc + TMO + 1;
                            end
                            expQ.push_back(e);
                            rdDue = e.due;
                            rspAt = (L > 0) ? cyc + L : -1;
                            waitEnd = e.due;
                            rdAddr = r.addr;
                            rdOutstanding = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic waitIdle(input string nm);
        int n;
        n = 0;
        while ((ifQ.size() > 0 || daQ.size() > 0 || IfReqValid || DaReqValid || busy ||
                accQ.size() > 0 || expQ.size() > 0) && n < 300) begin
            @(posedge CLK); #2;
            n++;
        end
        checks++;
        if (n >= 300) begin
            failures++;
            $display("FAIL %s_idle_timeout cyc=%0d actual=busy required=idle", nm, cyc);
        end
    endtask

    task automatic chkOutputsZero(input string nm);
        chk(nm, {8'd0, IfReqReady, DaReqReady, IfRspValid, IfRspErr, DaRspValid, DaRspErr,
                 MemCmdValid, MemCmdWrite, IfRspData, DaRspData, MemCmdAddr, MemCmdWData},
            128'd0);
    endtask

    initial begin : p_main
        int n;
        RST_N = 0;
        repeat (3) @(posedge CLK);
        #1 chkOutputsZero("reset_state");
        @(posedge CLK); #3 RST_N = 1;

        // IF read, 3-cycle controller latency.
        mem[16'h0010] = 32'hDEAD_BEEF;
        latQ.push_back(3);
        ifQ.push_back(16'h0010);
        waitIdle("if_read");
        chk("if_read_data", {96'd0, IfRspData}, {96'd0, 32'hDEAD_BEEF});

        // DA write stalled 5 cycles with an IF read queued behind it.
        stallQ.push_back(5);
        daQ.push_back('{wr: 1'b1, addr: 16'h0200, wd: 32'h1234_5678});
        ifQ.push_back(16'h0200);
        waitIdle("da_write");
        chk("write_readback", {96'd0, IfRspData}, {96'd0, 32'h1234_5678});

        // DA read that never gets a response.
        latQ.push_back(0);
        daQ.push_back('{wr: 1'b0, addr: 16'h0300, wd: 32'h0});
        waitIdle("da_timeout");
        chk("timeout_err_data", {95'd0, DaRspErr, DaRspData}, {95'd0, 1'b0, 32'h0});

        // Response arriving in the timeout cycle.
        mem[16'h0044] = 32'hC0FF_EE01;
        latQ.push_back(TMO);
        ifQ.push_back(16'h0044);
        waitIdle("rsp_at_timeout");
        chk("coincide_data", {96'd0, IfRspData}, {96'd0, 32'hC0FF_EE01});

        // Back-to-back reads from both requesters.
        ifRate = 100; daRate = 100; daWrPct = 0; randEn = 1;
        repeat (60) @(posedge CLK);
        randEn = 0;
        waitIdle("alternate");

        // Random mixed traffic.
        ifRate = 40; daRate = 40; daWrPct = 50; randEn = 1;
        repeat (2500) @(posedge CLK);
        randEn = 0;
        waitIdle("random");

        // Reset in WAIT_RSP, then a tie must go to IF.
        latQ.push_back(0);
        daQ.push_back('{wr: 1'b0, addr: 16'h0011, wd: 32'h0});
        n = 0;
        while (!rdOutstanding && n < 50) begin
            @(posedge CLK); n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL wait_rsp_entry cyc=%0d actual=no_read required=read_in_flight", cyc);
        end
        repeat (3) @(posedge CLK);
        #3 RST_N = 0;
        #1 chkOutputsZero("async_reset");
        repeat (2) @(posedge CLK);
        #3 RST_N = 1;
        mem[16'h0022] = 32'h0BAD_F00D;
        ifQ.push_back(16'h0022);
        daQ.push_back('{wr: 1'b0, addr: 16'h0023, wd: 32'h0});
        waitIdle("post_reset");
        chk("post_reset_if_data", {96'd0, IfRspData}, {96'd0, 32'h0BAD_F00D});

        repeat (20) @(posedge CLK);
        chk("queues_drained", {64'd0, 32'(accQ.size()), 32'(expQ.size())}, 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : p_watchdog
        #2_000_000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_oisc_mem_arbiter
`default_nettype wire
